// File: rtl/playcity_pkg.sv
// Shared encodings for the PlayCity bus master: command kinds, bus addresses,
// RETI opcodes, FSM state constants and the queued command layout.
package playcity_pkg;

    localparam logic [1:0] KIND_AY      = 2'b00;
    localparam logic [1:0] KIND_CTC     = 2'b01;
    localparam logic [1:0] KIND_SOFTRST = 2'b10;
    localparam logic [1:0] KIND_RSVD    = 2'b11;

    localparam logic [7:0]  PC_AY_DATA_HI = 8'hF8;
    localparam logic [7:0]  PC_AY_ADDR_HI = 8'hF9;
    localparam logic [15:0] PC_CTC_BASE   = 16'hF880;
    localparam logic [15:0] PC_SOFTRST    = 16'hF8FF;

    localparam logic [7:0] RETI_OP1 = 8'hED;
    localparam logic [7:0] RETI_OP2 = 8'h4D;

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE        = 4'd0;
    localparam state_t ST_FETCH       = 4'd1;
    localparam state_t ST_IO_SETUP    = 4'd2;
    localparam state_t ST_IO_STROBE   = 4'd3;
    localparam state_t ST_IO_HOLD     = 4'd4;
    localparam state_t ST_INTA_SETUP  = 4'd5;
    localparam state_t ST_INTA_STROBE = 4'd6;
    localparam state_t ST_INTA_HOLD   = 4'd7;
    localparam state_t ST_RETI_SETUP  = 4'd8;
    localparam state_t ST_RETI_STROBE = 4'd9;
    localparam state_t ST_RETI_HOLD   = 4'd10;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] chan;
        logic [3:0] regnum;
        logic [7:0] data;
    } cmd_t;

    // AY commands take two cycles: register select (F9xx) then data (F8xx).
    function automatic logic [15:0] bus_addr(input cmd_t c, input logic data_phase);
        logic [15:0] a;
        case (c.kind)
            KIND_AY:  a = {(data_phase ? PC_AY_DATA_HI : PC_AY_ADDR_HI), 4'h8, c.chan, 2'b00};
            KIND_CTC: a = {PC_CTC_BASE[15:2], c.chan};
            default:  a = PC_SOFTRST;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] bus_data(input cmd_t c, input logic data_phase);
        logic [7:0] d;
        case (c.kind)
            KIND_AY:      d = data_phase ? c.data : {4'h0, c.regnum};
            KIND_SOFTRST: d = 8'h00;
            default:      d = c.data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/playcity_cmd_fifo.sv
// Synchronous command FIFO; full is derived from the registered count, so a
// push is never taken while full even if a pop happens on the same clock.
module playcity_cmd_fifo
    import playcity_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/playcity_bus_master.sv
// Z80-side initiator for PlayCity: replays queued AY/CTC/reset commands as
// Z80 I/O write cycles and answers interrupts with INTA followed by RETI.
module playcity_bus_master
    import playcity_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int STROBE_TICKS = 2,
    parameter bit IRQ_ACK_EN   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        phi_en,
    // Handshake: a command is taken on any clock where cmd_valid and cmd_ready are both high.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic [1:0]  cmd_chan,
    input  logic [3:0]  cmd_reg,
    input  logic [7:0]  cmd_data,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic [7:0]  cpu_di,
    input  logic [7:0]  din,
    output logic        m1_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        int_n,
    output logic [7:0]  irq_vector,
    output logic        irq_ack,
    output logic        busy,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] STB_LAST = 4'(STROBE_TICKS);

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic        second_q, second_d;
    logic [3:0]  tick_q, tick_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        m1_n_q, m1_n_d, iorq_n_q, iorq_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [7:0]  irq_vector_q, irq_vector_d;
    logic        irq_ack_q, irq_ack_d;

    cmd_t fifo_rdata;
    logic fifo_pop, fifo_empty, fifo_full;

    playcity_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (cmd_valid && cmd_ready),
        .wdata  ({cmd_kind, cmd_chan, cmd_reg, cmd_data}),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        second_d     = second_q;
        tick_d       = tick_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        cpu_di_d     = cpu_di_q;
        m1_n_d       = m1_n_q;
        iorq_n_d     = iorq_n_q;
        rd_n_d       = rd_n_q;
        wr_n_d       = wr_n_q;
        irq_vector_d = irq_vector_q;
        irq_ack_d    = 1'b0;
        fifo_pop     = 1'b0;
        if (phi_en) begin
            case (state_q)
                // Interrupts are only arbitrated here, so an AY pair is never split.
                ST_IDLE: begin
                    if (IRQ_ACK_EN && !int_n) begin
                        state_d = ST_INTA_SETUP;
                        m1_n_d  = 1'b0;
                    end else if (!fifo_empty) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    second_d = 1'b0;
                    if (fifo_rdata.kind == KIND_RSVD) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = bus_addr(fifo_rdata, 1'b0);
                        dout_d  = bus_data(fifo_rdata, 1'b0);
                        state_d = ST_IO_SETUP;
                    end
                end
                ST_IO_SETUP: begin
                    state_d  = ST_IO_STROBE;
                    iorq_n_d = 1'b0;
                    wr_n_d   = 1'b0;
                    tick_d   = 4'd1;
                end
                ST_IO_STROBE: begin
                    if (tick_q == STB_LAST) begin
                        state_d  = ST_IO_HOLD;
                        iorq_n_d = 1'b1;
                        wr_n_d   = 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                ST_IO_HOLD: begin
                    if (cmd_q.kind == KIND_AY && !second_q) begin
                        second_d = 1'b1;
                        addr_d   = bus_addr(cmd_q, 1'b1);
                        dout_d   = bus_data(cmd_q, 1'b1);
                        state_d  = ST_IO_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_INTA_SETUP: begin
                    state_d  = ST_INTA_STROBE;
                    iorq_n_d = 1'b0;
                    tick_d   = 4'd1;
                end
                ST_INTA_STROBE: begin
                    if (tick_q == STB_LAST) begin
                        irq_vector_d = din;
                        irq_ack_d    = 1'b1;
                        m1_n_d       = 1'b1;
                        iorq_n_d     = 1'b1;
                        state_d      = ST_INTA_HOLD;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                ST_INTA_HOLD: begin
                    state_d  = ST_RETI_SETUP;
                    cpu_di_d = RETI_OP1;
                    second_d = 1'b0;
                end
                ST_RETI_SETUP: begin
                    state_d = ST_RETI_STROBE;
                    m1_n_d  = 1'b0;
                    rd_n_d  = 1'b0;
                    tick_d  = 4'd1;
                end
                ST_RETI_STROBE: begin
                    if (tick_q == STB_LAST) begin
                        state_d = ST_RETI_HOLD;
                        m1_n_d  = 1'b1;
                        rd_n_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                ST_RETI_HOLD: begin
                    if (!second_q) begin
                        second_d = 1'b1;
                        cpu_di_d = RETI_OP2;
                        state_d  = ST_RETI_SETUP;
                    end else begin
                        cpu_di_d = 8'h00;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            second_q     <= 1'b0;
            tick_q       <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            cpu_di_q     <= '0;
            m1_n_q       <= 1'b1;
            iorq_n_q     <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            irq_vector_q <= '0;
            irq_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            second_q     <= second_d;
            tick_q       <= tick_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            cpu_di_q     <= cpu_di_d;
            m1_n_q       <= m1_n_d;
            iorq_n_q     <= iorq_n_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            irq_vector_q <= irq_vector_d;
            irq_ack_q    <= irq_ack_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign addr       = addr_q;
    assign dout       = dout_q;
    assign cpu_di     = cpu_di_q;
    assign m1_n       = m1_n_q;
    assign iorq_n     = iorq_n_q;
    assign rd_n       = rd_n_q;
    assign wr_n       = wr_n_q;
    assign irq_vector = irq_vector_q;
    assign irq_ack    = irq_ack_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_playcity_bus_master.sv
// Self-checking bench for playcity_bus_master: a bus monitor turns observed
// write, INTA and M1 fetch cycles into events compared against an expected queue.
module tb_playcity_bus_master;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        phi_en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_kind = '0;
    logic [1:0]  cmd_chan = '0;
    logic [3:0]  cmd_reg = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  cpu_di;
    logic [7:0]  din = 8'h10;
    logic        m1_n, iorq_n, rd_n, wr_n;
    logic        int_n = 1'b1;
    logic [7:0]  irq_vector;
    logic        irq_ack;
    logic        busy;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int phi_div = 4;
    int phi_cnt = 0;
    bit chk_width = 1'b1;

    // Event word: {type, addr, data}; 1 = IO write, 2 = INTA vector, 3 = M1 fetch (iorq_n high), 4 = M1 fetch with iorq_n low
    logic [31:0] exp_q[$];

    playcity_bus_master dut (
        .clock(clock), .reset_n(reset_n), .phi_en(phi_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_chan(cmd_chan), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .addr(addr), .dout(dout), .cpu_di(cpu_di), .din(din),
        .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .int_n(int_n), .irq_vector(irq_vector), .irq_ack(irq_ack),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / phi_en ----------------
    initial forever #5 clock = ~clock;

    initial forever begin
        @(negedge clock);
        if (phi_div == 0) begin
            phi_en = 1'b0;
        end else begin
            phi_cnt = phi_cnt + 1;
            if (phi_cnt >= phi_div) begin
                phi_cnt = 0;
                phi_en = 1'b1;
            end else begin
                phi_en = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic prev_wr = 1'b1, prev_rd = 1'b1, prev_m1 = 1'b1, prev_iorq = 1'b1;
    int   low_cnt = 0;

    task automatic sb_compare(input logic [31:0] got);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_event: got %h, expected no event", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL bus_event: got %h expected %h", got, exp);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (prev_wr && !wr_n) sb_compare({8'd1, addr, dout});
            if (!rd_n && prev_rd && !m1_n) sb_compare({(iorq_n ? 8'd3 : 8'd4), 16'h0000, cpu_di});
            if (irq_ack) begin
                sb_compare({8'd2, 16'h0000, irq_vector});
                checks++;
                if ({prev_m1, prev_iorq, prev_rd, prev_wr} !== 4'b0011) begin
                    errors++;
                    $display("FAIL inta_strobes: m1/iorq/rd/wr %b expected 0011",
                             {prev_m1, prev_iorq, prev_rd, prev_wr});
                end
            end
            if (!wr_n) low_cnt = prev_wr ? 1 : low_cnt + 1;
            if (!prev_wr && wr_n && chk_width && phi_div > 0) begin
                checks++;
                if (low_cnt != 2 * phi_div) begin
                    errors++;
                    $display("FAIL wr_width: %0d clocks expected %0d", low_cnt, 2 * phi_div);
                end
            end
        end
        prev_wr = wr_n; prev_rd = rd_n; prev_m1 = m1_n; prev_iorq = iorq_n;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] ay_lo(input logic [1:0] ch);
        return 8'h80 | {4'h0, ch, 2'b00};
    endfunction

    task automatic push_cmd(input logic [1:0] k, input logic [1:0] ch,
                            input logic [3:0] r, input logic [7:0] d);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready %b expected 1", cmd_ready);
        end else begin
            case (k)
                2'b00: begin
                    exp_q.push_back({8'd1, 8'hF9, ay_lo(ch), 4'h0, r});
                    exp_q.push_back({8'd1, 8'hF8, ay_lo(ch), d});
                end
                2'b01: exp_q.push_back({8'd1, 16'hF880 + {14'h0, ch}, d});
                2'b10: exp_q.push_back({8'd1, 16'hF8FF, 8'h00});
                default: ;
            endcase
            cmd_kind = k; cmd_chan = ch; cmd_reg = r; cmd_data = d;
            cmd_valid = 1'b1;
            @(negedge clock);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clock);
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: busy %b pending %0d expected busy 0 pending 0",
                     name, busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_wr_low(input string name);
        int n = 0;
        while (wr_n !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (wr_n !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_wr_timeout: wr_n %b expected 0", name, wr_n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (addr !== 16'h0000 || dout !== 8'h00 || cpu_di !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: addr %h dout %h cpu_di %h expected 0000 00 00", addr, dout, cpu_di);
        end
        checks++;
        if ({m1_n, iorq_n, rd_n, wr_n} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_strobes: %b expected 1111", {m1_n, iorq_n, rd_n, wr_n});
        end
        checks++;
        if (irq_vector !== 8'h00 || irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: vector %h ack %b expected 00 0", irq_vector, irq_ack);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: ready %b busy %b expected 1 0", cmd_ready, busy);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_ay_left();
        phi_div = 4;
        push_cmd(2'b00, 2'b01, 4'd7, 8'h3F);
        wait_drain("ay_left");
    endtask

    task automatic test_ay_both();
        phi_div = 4;
        push_cmd(2'b00, 2'b11, 4'd0, 8'h55);
        wait_drain("ay_both");
    endtask

    task automatic test_ctc_softrst();
        phi_div = 2;
        push_cmd(2'b01, 2'b10, 4'd0, 8'h47);
        push_cmd(2'b10, 2'b00, 4'd0, 8'h00);
        push_cmd(2'b11, 2'b01, 4'd3, 8'hA5);
        push_cmd(2'b01, 2'b01, 4'd0, 8'hC3);
        wait_drain("ctc_softrst");
    endtask

    task automatic test_fifo_full();
        phi_div = 0;
        for (int i = 0; i < 8; i++)
            push_cmd(2'b01, 2'($urandom_range(0, 3)), 4'd0, 8'($urandom_range(0, 255)));
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_ready: cmd_ready %b expected 0", cmd_ready);
        end
        cmd_kind = 2'b01; cmd_chan = 2'b11; cmd_data = 8'hEE; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1 || wr_n !== 1'b1 || dbg_state !== 4'd0) begin
                errors++;
                $display("FAIL fifo_frozen: ready %b busy %b wr_n %b state %0d expected 0 1 1 0",
                         cmd_ready, busy, wr_n, dbg_state);
            end
        end
        cmd_valid = 1'b0;
        phi_div = 1;
        wait_drain("fifo_full");
    endtask

    task automatic test_back_to_back();
        phi_div = 1;
        for (int i = 0; i < 6; i++)
            push_cmd(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        wait_drain("back_to_back");
    endtask

    task automatic test_irq();
        int n = 0;
        phi_div = 2;
        din = 8'h10;
        push_cmd(2'b00, 2'b01, 4'd2, 8'h99);
        wait_wr_low("irq");
        int_n = 1'b0;
        exp_q.push_back({8'd2, 16'h0000, 8'h10});
        exp_q.push_back({8'd3, 16'h0000, 8'hED});
        exp_q.push_back({8'd3, 16'h0000, 8'h4D});
        while (irq_ack !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        int_n = 1'b1;
        checks++;
        if (irq_ack !== 1'b1) begin
            errors++;
            $display("FAIL irq_ack_seen: irq_ack %b expected 1", irq_ack);
        end
        @(negedge clock);
        checks++;
        if (irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack_pulse: irq_ack %b expected 0", irq_ack);
        end
        wait_drain("irq");
        checks++;
        if (irq_vector !== 8'h10 || cpu_di !== 8'h00) begin
            errors++;
            $display("FAIL irq_final: vector %h cpu_di %h expected 10 00", irq_vector, cpu_di);
        end
    endtask

    task automatic test_reset_mid();
        phi_div = 4;
        push_cmd(2'b01, 2'b11, 4'd0, 8'h5A);
        push_cmd(2'b01, 2'b00, 4'd0, 8'h11);
        push_cmd(2'b10, 2'b00, 4'd0, 8'h00);
        wait_wr_low("reset_mid");
        repeat (2) @(negedge clock);
        chk_width = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr_n !== 1'b1 || iorq_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_strobes: wr_n %b iorq_n %b expected 1 1", wr_n, iorq_n);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || irq_vector !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_status: ready %b busy %b vector %h expected 1 0 00",
                     cmd_ready, busy, irq_vector);
        end
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk_width = 1'b1;
        push_cmd(2'b01, 2'b01, 4'd0, 8'h3C);
        wait_drain("reset_mid");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ay_left();
        test_ay_both();
        test_ctc_softrst();
        test_fifo_full();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
